// File: rtl/cpu65_pkg.sv
// Shared definitions for the 65C02 interrupt/reset sequencer.
// Contents: sequencer state encoding, serviced-source kinds, push_sel byte
// encodings, the IRQ index width and the default 65C02 vector addresses.
package cpu65_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_PUSH_H,
    ST_PUSH_L,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI,
    ST_DONE
  } seq_state_e;

  // Kind of event being serviced; the vector is derived from this on entry
  // to VEC_LO.
  typedef enum logic [1:0] {
    SRC_RST,
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } seq_src_e;

  localparam logic [1:0] PUSH_SEL_PCH = 2'b00;
  localparam logic [1:0] PUSH_SEL_PCL = 2'b01;
  localparam logic [1:0] PUSH_SEL_P   = 2'b10;

  localparam int IRQ_IDX_W = 3;

  localparam logic [15:0] DEF_NMI_VEC      = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC      = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC      = 16'hFFFE;
  localparam logic [15:0] DEF_EXT_VEC_BASE = 16'hFFF0;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder for the vectored IRQ lines.
// Ports:
//   req   in  N          active-high requests, bit 0 has the highest priority
//   valid out 1          at least one request is active
//   idx   out IRQ_IDX_W  index of the lowest-numbered active request (0 if none)
module irq_prio_enc
  import cpu65_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] idx
);

  // Scanning from the top down lets the lowest active index overwrite the rest.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/cpu_interrupt_sequencer.sv
// Interrupt/reset sequencer for the 65C02 core with NUM_IRQ vectored IRQs.
// At instruction boundaries it arbitrates pending NMI, BRK and the IRQ lines,
// then owns the bus for the stack push (PCH, PCL, P) and the two-byte vector
// fetch, finishing with a one-cycle PC load.
// Ports:
//   PHI2      in   clock, rising edge
//   RESB      in   synchronous active-low reset
//   NMIB      in   NMI, falling-edge sensitive
//   irq_n     in   NUM_IRQ active-low level IRQs, index 0 highest priority
//   i_flag    in   P.I (masks irq_n only)
//   boundary  in   last cycle of the current instruction
//   brk       in   BRK decoded, qualified by boundary
//   rdy       in   0 freezes the sequencer (NMI edge detection keeps running)
//   db_in     in   data bus read value
//   busy      out  sequencer owns the bus
//   push_en   out  stack write of the push_sel byte
//   push_sel  out  00=PCH 01=PCL 10=P
//   b_push    out  B bit of the pushed P
//   vpb_n     out  vector pull, active-low
//   vec_addr  out  vector fetch address
//   pc_load   out  load pc_val into PC
//   pc_val    out  fetched vector {hi, lo}
//   set_i     out  set P.I together with pc_load
//   clr_d     out  clear P.D together with pc_load
//   irq_src   out  serviced IRQ index, NUM_IRQ for NMI/BRK/reset
module cpu_interrupt_sequencer
  import cpu65_pkg::*;
#(
  parameter int                NUM_IRQ      = 4,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] NMI_VEC      = ADDR_W'(DEF_NMI_VEC),
  parameter logic [ADDR_W-1:0] RST_VEC      = ADDR_W'(DEF_RST_VEC),
  parameter logic [ADDR_W-1:0] IRQ_VEC      = ADDR_W'(DEF_IRQ_VEC),
  parameter logic [ADDR_W-1:0] EXT_VEC_BASE = ADDR_W'(DEF_EXT_VEC_BASE)
) (
  input  logic                 PHI2,
  input  logic                 RESB,
  input  logic                 NMIB,
  input  logic [NUM_IRQ-1:0]   irq_n,
  input  logic                 i_flag,
  input  logic                 boundary,
  input  logic                 brk,
  input  logic                 rdy,
  input  logic [7:0]           db_in,
  output logic                 busy,
  output logic                 push_en,
  output logic [1:0]           push_sel,
  output logic                 b_push,
  output logic                 vpb_n,
  output logic [ADDR_W-1:0]    vec_addr,
  output logic                 pc_load,
  output logic [ADDR_W-1:0]    pc_val,
  output logic                 set_i,
  output logic                 clr_d,
  output logic [IRQ_IDX_W-1:0] irq_src
);

  if (NUM_IRQ < 1 || NUM_IRQ > 6) begin : g_bad_num_irq
    $error("cpu_interrupt_sequencer: NUM_IRQ must lie in 1..6");
  end

  localparam logic [IRQ_IDX_W-1:0] SRC_NONE_IDX = IRQ_IDX_W'(NUM_IRQ);

  seq_state_e               state_q, state_d;
  seq_src_e                 src_q, sel_src;
  logic                     brk_q;
  logic                     nmi_pend_q;
  logic                     nmib_q;
  logic [IRQ_IDX_W-1:0]     irq_src_q, sel_idx, enc_idx;
  logic                     enc_vld, sel_valid;
  logic                     nmi_fall;
  logic                     take_nmi;
  logic [ADDR_W-1:0]        vec_q, vec_sel;
  logic [7:0]               lo_q, hi_q;

  function automatic logic [ADDR_W-1:0] irq_vector(input logic [IRQ_IDX_W-1:0] k);
    if (k == '0) return IRQ_VEC;
    return EXT_VEC_BASE + ADDR_W'(2 * (int'(k) - 1));
  endfunction

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (~irq_n),
    .valid (enc_vld),
    .idx   (enc_idx)
  );

  assign nmi_fall = nmib_q & ~NMIB;
  assign irq_src  = irq_src_q;

  // Source chosen at a boundary: NMI, then BRK, then unmasked IRQs.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = SRC_NMI;
    sel_idx   = SRC_NONE_IDX;
    if (nmi_pend_q) begin
      sel_valid = 1'b1;
    end else if (brk) begin
      sel_valid = 1'b1;
      sel_src   = SRC_BRK;
    end else if (!i_flag && enc_vld) begin
      sel_valid = 1'b1;
      sel_src   = SRC_IRQ;
      sel_idx   = enc_idx;
    end
  end

  // Vector resolution for the PUSH_P -> VEC_LO step. An NMI that became
  // pending during the pushes of a BRK/IRQ sequence takes over the vector.
  always_comb begin
    take_nmi = 1'b0;
    case (src_q)
      SRC_RST: vec_sel = RST_VEC;
      SRC_NMI: begin
        vec_sel  = NMI_VEC;
        take_nmi = 1'b1;
      end
      SRC_BRK: vec_sel = IRQ_VEC;
      default: vec_sel = irq_vector(irq_src_q);
    endcase
    if (nmi_pend_q && (src_q == SRC_BRK || src_q == SRC_IRQ)) begin
      vec_sel  = NMI_VEC;
      take_nmi = 1'b1;
    end
  end

  always_ff @(posedge PHI2) begin
    if (!RESB) begin
      state_q    <= ST_RST;
      nmi_pend_q <= 1'b0;
      nmib_q     <= 1'b1;
      src_q      <= SRC_RST;
      brk_q      <= 1'b0;
      irq_src_q  <= SRC_NONE_IDX;
    end else begin
      nmib_q <= NMIB;
      // A fresh falling edge wins over the clear so it is never lost.
      if (nmi_fall) begin
        nmi_pend_q <= 1'b1;
      end else if (rdy && state_q == ST_PUSH_P && take_nmi) begin
        nmi_pend_q <= 1'b0;
      end
      if (rdy) begin
        state_q <= state_d;
        if (state_q == ST_IDLE && boundary && sel_valid) begin
          src_q     <= sel_src;
          brk_q     <= (sel_src == SRC_BRK);
          irq_src_q <= sel_idx;
        end
        if (state_q == ST_PUSH_P && take_nmi) begin
          irq_src_q <= SRC_NONE_IDX;
        end
      end
    end
  end

  // Vector and fetched bytes are pure data and need no reset.
  always_ff @(posedge PHI2) begin
    if (rdy) begin
      if (state_q == ST_PUSH_P) vec_q <= vec_sel;
      if (state_q == ST_VEC_LO) lo_q  <= db_in;
      if (state_q == ST_VEC_HI) hi_q  <= db_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    push_en  = 1'b0;
    push_sel = PUSH_SEL_PCH;
    b_push   = 1'b0;
    vpb_n    = 1'b1;
    vec_addr = '0;
    pc_load  = 1'b0;
    pc_val   = '0;
    set_i    = 1'b0;
    clr_d    = 1'b0;
    case (state_q)
      ST_RST: begin
        if (rdy) state_d = ST_PUSH_H;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (rdy && boundary && sel_valid) state_d = ST_PUSH_H;
      end
      ST_PUSH_H: begin
        push_en  = (src_q != SRC_RST);
        push_sel = PUSH_SEL_PCH;
        b_push   = brk_q;
        if (rdy) state_d = ST_PUSH_L;
      end
      ST_PUSH_L: begin
        push_en  = (src_q != SRC_RST);
        push_sel = PUSH_SEL_PCL;
        b_push   = brk_q;
        if (rdy) state_d = ST_PUSH_P;
      end
      ST_PUSH_P: begin
        push_en  = (src_q != SRC_RST);
        push_sel = PUSH_SEL_P;
        b_push   = brk_q;
        if (rdy) state_d = ST_VEC_LO;
      end
      ST_VEC_LO: begin
        vpb_n    = 1'b0;
        vec_addr = vec_q;
        b_push   = brk_q;
        if (rdy) state_d = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        vpb_n    = 1'b0;
        vec_addr = vec_q + ADDR_W'(1);
        b_push   = brk_q;
        if (rdy) state_d = ST_DONE;
      end
      ST_DONE: begin
        pc_load = 1'b1;
        pc_val  = ADDR_W'({hi_q, lo_q});
        set_i   = 1'b1;
        clr_d   = 1'b1;
        b_push  = brk_q;
        if (rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_interrupt_sequencer.sv
module tb_cpu_interrupt_sequencer;

  localparam int NUM_IRQ = 4;
  localparam int ADDR_W  = 16;
  localparam logic [15:0] V_NMI = 16'hFFFA;
  localparam logic [15:0] V_RST = 16'hFFFC;
  localparam logic [15:0] V_IRQ = 16'hFFFE;
  localparam logic [15:0] V_EXT = 16'hFFF0;

  logic                PHI2 = 1'b0;
  logic                RESB = 1'b0;
  logic                NMIB = 1'b1;
  logic [NUM_IRQ-1:0]  irq_n = '1;
  logic                i_flag = 1'b1;
  logic                boundary = 1'b0;
  logic                brk = 1'b0;
  logic                rdy = 1'b1;
  logic [7:0]          db_in;
  logic                busy, push_en, b_push, vpb_n, pc_load, set_i, clr_d;
  logic [1:0]          push_sel;
  logic [ADDR_W-1:0]   vec_addr, pc_val;
  logic [2:0]          irq_src;

  logic [7:0] mem [16];
  assign db_in = mem[vec_addr[3:0]];

  cpu_interrupt_sequencer #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) dut (
    .PHI2(PHI2), .RESB(RESB), .NMIB(NMIB), .irq_n(irq_n), .i_flag(i_flag),
    .boundary(boundary), .brk(brk), .rdy(rdy), .db_in(db_in), .busy(busy),
    .push_en(push_en), .push_sel(push_sel), .b_push(b_push), .vpb_n(vpb_n),
    .vec_addr(vec_addr), .pc_load(pc_load), .pc_val(pc_val), .set_i(set_i),
    .clr_d(clr_d), .irq_src(irq_src)
  );

  always #5 PHI2 = ~PHI2;

  typedef struct {
    logic [15:0] vec;
    logic [15:0] pcv;
    logic [2:0]  src;
    logic        bp;
    logic        pushes;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic pend_m  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [15:0] vec_of(input int kind, input int idx);
    case (kind)
      0:       return V_RST;
      1:       return V_NMI;
      2:       return V_IRQ;
      default: return (idx == 0) ? V_IRQ : 16'(V_EXT + 2 * (idx - 1));
    endcase
  endfunction

  function automatic logic [15:0] exp_pc(input logic [15:0] v);
    logic [15:0] v1;
    v1 = v + 16'd1;
    return {mem[v1[3:0]], mem[v[3:0]]};
  endfunction

  // Monitor: samples 1 time unit after each rising edge; an edge with rdy=1
  // moves the sequencer into the state now visible on the outputs.
  int          obs_push_cnt = 0;
  logic [5:0]  obs_pat = '0;
  int          obs_vec_cnt = 0;
  logic [15:0] obs_vlo = '0, obs_vhi = '0;
  logic        obs_bp = 1'b0;

  task automatic clr_obs();
    obs_push_cnt = 0;
    obs_pat      = '0;
    obs_vec_cnt  = 0;
    obs_vlo      = '0;
    obs_vhi      = '0;
    obs_bp       = 1'b0;
  endtask

  always @(posedge PHI2) begin
    exp_t e;
    #1;
    if (!RESB) begin
      clr_obs();
    end else if (rdy) begin
      if (push_en) begin
        obs_pat = {obs_pat[3:0], push_sel};
        obs_push_cnt++;
      end
      obs_bp = obs_bp | b_push;
      if (!vpb_n) begin
        if (obs_vec_cnt == 0) obs_vlo = vec_addr;
        else                  obs_vhi = vec_addr;
        obs_vec_cnt++;
      end
      if (pc_load) begin
        if (q.size() == 0) begin
          fail_now("unexpected_pc_load", "got pc_load=1, expected no sequence");
        end else begin
          e = q.pop_front();
          chk("vec_lo", obs_vlo, e.vec);
          chk("vec_hi", obs_vhi, 16'(e.vec + 16'd1));
          chk("vec_fetch_count", obs_vec_cnt, 2);
          chk("pc_val", pc_val, e.pcv);
          chk("irq_src", irq_src, e.src);
          chk("b_push", obs_bp, e.bp);
          chk("push_count", obs_push_cnt, e.pushes ? 3 : 0);
          if (e.pushes) chk("push_order", obs_pat, 6'b00_01_10);
          chk("set_i_clr_d", {set_i, clr_d}, 2'b11);
        end
        clr_obs();
      end
    end
  end

  task automatic tick();
    @(negedge PHI2);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    if (busy) fail_now("idle_timeout", "got busy=1 after 60 cycles, expected 0");
  endtask

  task automatic do_reset(input int cyc);
    int seen;
    RESB = 1'b0; boundary = 1'b0; brk = 1'b0; rdy = 1'b1; NMIB = 1'b1;
    repeat (cyc) tick();
    chk("rst_busy", busy, 1);
    chk("rst_vpb_n", vpb_n, 1);
    chk("rst_push_en", push_en, 0);
    chk("rst_pulses", {pc_load, set_i, clr_d}, 0);
    chk("rst_pc_val", pc_val, 0);
    chk("rst_irq_src", irq_src, NUM_IRQ);
    pend_m = 1'b0;
    q.push_back('{V_RST, exp_pc(V_RST), 3'(NUM_IRQ), 1'b0, 1'b0});
    RESB = 1'b1;
    seen = 0;
    for (int i = 1; i <= 12 && seen == 0; i++) begin
      tick();
      if (pc_load) seen = i;
    end
    chk("rst_pc_load_edge", seen, 6);
    wait_idle();
  endtask

  // f: edge (relative to the boundary edge) at which NMIB is first seen low; -1 none.
  task automatic run_txn(input logic [NUM_IRQ-1:0] irqv, input logic ifl, input logic b,
                         input int f, input logic stall);
    int   kind, idx;
    logic hij;
    exp_t e;
    kind = -1;
    idx  = NUM_IRQ;
    if (pend_m) kind = 1;
    else if (b) kind = 2;
    else if (!ifl) begin
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
        if (!irqv[k]) begin
          kind = 3;
          idx  = k;
        end
      end
    end
    if (kind == 1) f = -1;
    hij = (kind == 2 || kind == 3) && f >= 0 && f <= 2;
    if (kind >= 0) begin
      e.bp     = (kind == 2);
      e.pushes = 1'b1;
      if (kind == 1 || hij) begin
        e.vec = V_NMI;
        e.src = 3'(NUM_IRQ);
      end else begin
        e.vec = vec_of(kind, idx);
        e.src = (kind == 3) ? 3'(idx) : 3'(NUM_IRQ);
      end
      e.pcv = exp_pc(e.vec);
      q.push_back(e);
    end
    if (kind == 1) pend_m = 1'b0;
    if (f >= 0 && !hij) pend_m = 1'b1;

    irq_n = irqv; i_flag = ifl; brk = b; boundary = 1'b1; rdy = 1'b1;
    if (f == 0) NMIB = 1'b0;
    tick();
    boundary = 1'b0;
    brk      = 1'b0;
    irq_n    = NUM_IRQ'($urandom);
    if (kind < 0) chk("no_select_busy", busy, 0);
    for (int c = 1; c <= 8; c++) begin
      if (c == f) NMIB = 1'b0;
      if (stall && f < 0 && c >= 2) rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    rdy  = 1'b1;
    NMIB = 1'b1;
    tick();
    wait_idle();
    irq_n = '1;
  endtask

  task automatic stall_test();
    q.push_back('{V_IRQ, exp_pc(V_IRQ), 3'd0, 1'b0, 1'b1});
    irq_n = 4'b1110; i_flag = 1'b0; boundary = 1'b1; rdy = 1'b1;
    tick();
    boundary = 1'b0;
    repeat (4) tick();
    chk("stall_entry_vec_addr", vec_addr, 16'hFFFF);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_vec_addr", vec_addr, 16'hFFFF);
      chk("stall_vpb_n", vpb_n, 0);
      chk("stall_pc_load", pc_load, 0);
    end
    rdy = 1'b1;
    tick();
    chk("stall_pc_load_late", pc_load, 1);
    wait_idle();
    irq_n = '1; i_flag = 1'b1;
  endtask

  task automatic abort_test();
    irq_n = 4'b1011; i_flag = 1'b0; boundary = 1'b1; rdy = 1'b1;
    tick();
    boundary = 1'b0;
    repeat (2) tick();
    chk("abort_in_push_p", {push_en, push_sel}, 3'b110);
    irq_n = '1; i_flag = 1'b1;
    // The IRQ sequence is abandoned: nothing is queued for it.
    do_reset(3);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NUM_IRQ-1:0] irqv;
    logic ifl, b, st;
    int   f;
    for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
    mem[12] = 8'h00;
    mem[13] = 8'h80;

    do_reset(3);
    run_txn(4'b1101, 1'b0, 1'b0, -1, 1'b0);
    run_txn(4'b1110, 1'b1, 1'b0, -1, 1'b0);
    run_txn(4'b1110, 1'b1, 1'b1, -1, 1'b0);
    run_txn(4'b1111, 1'b1, 1'b1, 2, 1'b0);
    run_txn(4'b1111, 1'b1, 1'b0, -1, 1'b0);
    stall_test();
    abort_test();

    for (int n = 0; n < 40; n++) begin
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
      irqv = NUM_IRQ'($urandom);
      ifl  = ($urandom_range(0, 3) == 0);
      b    = ($urandom_range(0, 3) == 0);
      f    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      st   = (f < 0) && ($urandom_range(0, 2) == 0);
      run_txn(irqv, ifl, b, f, st);
    end

    wait_idle();
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
